// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM/WB pipeline stage with a 2-entry skid buffer.
//
// Carries LANES parallel GPR writebacks plus an optional HI/LO writeback from
// MEM to WB under a valid/ready handshake. mem_ready is a flop output, so it
// never depends combinationally on wb_ready. flush squashes every buffered
// entry on the next edge, the same way rst does.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous squash of all buffered entries
//   mem_valid  in   MEM presents an entry
//   mem_ready  out  buffer can accept an entry (registered)
//   mem_wd     in   LANES*ADDR_W GPR destination addresses
//   mem_wreg   in   LANES GPR write enables
//   mem_wdata  in   LANES*DATA_W GPR write data
//   mem_whilo  in   HI/LO write enable
//   mem_hi     in   HI data
//   mem_lo     in   LO data
//   wb_valid   out  head entry valid (registered)
//   wb_ready   in   WB consumes the head entry
//   wb_*       out  fields of the head entry, all zero when empty
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | no entry held, main and skid cleared
// ONE   | main holds the head entry, skid cleared
// TWO   | main holds head, skid holds the next entry
module mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [LANES*ADDR_W-1:0] mem_wd,
  input  logic [LANES-1:0]        mem_wreg,
  input  logic [LANES*DATA_W-1:0] mem_wdata,
  input  logic                    mem_whilo,
  input  logic [DATA_W-1:0]       mem_hi,
  input  logic [DATA_W-1:0]       mem_lo,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [LANES*ADDR_W-1:0] wb_wd,
  output logic [LANES-1:0]        wb_wreg,
  output logic [LANES*DATA_W-1:0] wb_wdata,
  output logic                    wb_whilo,
  output logic [DATA_W-1:0]       wb_hi,
  output logic [DATA_W-1:0]       wb_lo
);

  // Entry layout: {wd, wreg, wdata, whilo, hi, lo}
  localparam int ENT_W = LANES*ADDR_W + LANES + LANES*DATA_W + 1 + 2*DATA_W;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  typedef enum logic [1:0] {M_HOLD, M_LOAD_IN, M_LOAD_SKID, M_CLEAR} main_op_t;

  state_t         state_q, state_nxt;
  main_op_t       main_op;
  logic           skid_load, skid_clear;
  logic           mem_ready_q, wb_valid_q;
  logic           push, pop;
  logic [ENT_W-1:0] in_ent, main_q, skid_q;

  assign push   = mem_valid & mem_ready_q;
  assign pop    = wb_valid_q & wb_ready;
  assign in_ent = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo};

  // State register and datapath storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      mem_ready_q <= 1'b1;
      wb_valid_q  <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_nxt;
      // Both handshake flags are derived from the next state so they are
      // valid in the same cycle the new state takes effect.
      mem_ready_q <= (state_nxt != TWO);
      wb_valid_q  <= (state_nxt != EMPTY);
      case (main_op)
        M_LOAD_IN:   main_q <= in_ent;
        M_LOAD_SKID: main_q <= skid_q;
        M_CLEAR:     main_q <= '0;
        default:     main_q <= main_q;
      endcase
      if (skid_clear)
        skid_q <= '0;
      else if (skid_load)
        skid_q <= in_ent;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)
            state_nxt = TWO;
          else if (!push && pop)
            state_nxt = EMPTY;
        end
        TWO:     if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Datapath control
  always_comb begin
    main_op    = M_HOLD;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      main_op    = M_CLEAR;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (push) main_op = M_LOAD_IN;
        ONE: begin
          if (push && pop)
            main_op = M_LOAD_IN;
          else if (push)
            skid_load = 1'b1;
          else if (pop)
            main_op = M_CLEAR;   // keep the empty slot's enables at zero
        end
        TWO: begin
          if (pop) begin
            main_op    = M_LOAD_SKID;
            skid_clear = 1'b1;
          end
        end
        default: begin
          main_op    = M_CLEAR;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign mem_ready = mem_ready_q;
  assign wb_valid  = wb_valid_q;
  assign {wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo} = main_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
module tb_mem_wb_skid;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int L  = 2;
  localparam int EW = L*AW + L + L*DW + 1 + 2*DW;

  logic            clk = 1'b0;
  logic            rst, flush, mem_valid, wb_ready;
  logic            mem_ready, wb_valid;
  logic [L*AW-1:0] mem_wd, wb_wd;
  logic [L-1:0]    mem_wreg, wb_wreg;
  logic [L*DW-1:0] mem_wdata, wb_wdata;
  logic            mem_whilo, wb_whilo;
  logic [DW-1:0]   mem_hi, mem_lo, wb_hi, wb_lo;

  mem_wb_skid #(.DATA_W(DW), .ADDR_W(AW), .LANES(L)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two whole entries.
  logic [EW-1:0] mq[$];

  task automatic compare_all();
    logic [EW-1:0] h;
    h = (mq.size() > 0) ? mq[0] : '0;
    check("mem_ready", 256'(mem_ready), 256'(mq.size() < 2));
    check("wb_valid",  256'(wb_valid),  256'(mq.size() > 0));
    check("wb_wd",     256'(wb_wd),     256'(h[EW-1 -: L*AW]));
    check("wb_wreg",   256'(wb_wreg),   256'(h[EW-1-L*AW -: L]));
    check("wb_wdata",  256'(wb_wdata),  256'(h[2*DW+1 +: L*DW]));
    check("wb_whilo",  256'(wb_whilo),  256'(h[2*DW]));
    check("wb_hi",     256'(wb_hi),     256'(h[DW +: DW]));
    check("wb_lo",     256'(wb_lo),     256'(h[0 +: DW]));
  endtask

  // One clock: the model consumes the same inputs the DUT saw at the edge.
  task automatic step();
    bit do_push, do_pop;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() > 0) && wb_ready;
      do_push = mem_valid && (mq.size() < 2);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo});
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [L*AW-1:0] wd, input logic [L-1:0] we,
                       input logic [L*DW-1:0] wdat, input logic hl,
                       input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    mem_valid = v; mem_wd = wd; mem_wreg = we; mem_wdata = wdat;
    mem_whilo = hl; mem_hi = hi; mem_lo = lo;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, L*AW'($urandom), L'($urandom), {$urandom, $urandom},
          1'($urandom), $urandom, $urandom);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    drive(1'b1, {5'd9, 5'd4}, 2'b11, {32'h5, 32'h6}, 1'b1, 32'h7, 32'h8);

    // Reset held two cycles with mem_valid high: nothing captured
    step(); step();
    rst = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    step();
    check("reset_valid_const", 256'(wb_valid), 256'(0));
    check("reset_ready_const", 256'(mem_ready), 256'(1));

    // Streaming with wb_ready high
    wb_ready = 1'b1;
    drive(1'b1, {5'd7, 5'd5}, 2'b11, {32'h1, 32'hDEADBEEF}, 1'b0, '0, '0);
    step();
    check("stream_a_lane0", 256'(wb_wdata[31:0]), 256'(32'hDEADBEEF));
    check("stream_a_lane1_wd", 256'(wb_wd[9:5]), 256'(7));
    drive(1'b1, {5'd0, 5'd3}, 2'b01, {32'h0, 32'h2}, 1'b0, '0, '0);
    step();
    check("stream_b_lane0", 256'(wb_wdata[31:0]), 256'(32'h2));
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    step(); step();

    // Backpressure: fill to two entries, then drain
    wb_ready = 1'b0;
    drive(1'b1, {5'd1, 5'd1}, 2'b01, {32'h0, 32'h11}, 1'b0, '0, '0);
    step();
    drive(1'b1, {5'd2, 5'd2}, 2'b01, {32'h0, 32'h22}, 1'b0, '0, '0);
    step();
    check("bp_full_ready_const", 256'(mem_ready), 256'(0));
    drive(1'b1, {5'd3, 5'd3}, 2'b01, {32'h0, 32'h99}, 1'b0, '0, '0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    wb_ready = 1'b1;
    step();
    check("bp_b_after_a", 256'(wb_wdata[31:0]), 256'(32'h22));
    step(); step();

    // Flush with a full buffer and a concurrent push
    wb_ready = 1'b0;
    drive_rand(1'b1); step();
    drive_rand(1'b1); step();
    flush = 1'b1;
    drive(1'b1, {5'd6, 5'd6}, 2'b11, {32'h33, 32'h33}, 1'b0, '0, '0);
    step();
    flush = 1'b0; wb_ready = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    step(); step();

    // HI/LO path
    drive(1'b1, '0, 2'b00, '0, 1'b1, 32'hAAAA0000, 32'h0000BBBB);
    step();
    check("hilo_hi_const", 256'(wb_hi), 256'(32'hAAAA0000));
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    step();
    check("hilo_cleared", 256'(wb_whilo), 256'(0));

    // rst and flush together, then rst held against a push
    drive(1'b1, '0, '0, '0, 1'b0, '0, '0);
    step();
    rst = 1'b1; flush = 1'b1; drive_rand(1'b1);
    step();
    flush = 1'b0; drive_rand(1'b1);
    step();
    rst = 1'b0; drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      wb_ready = ($urandom_range(0, 99) < 60);
      drive_rand(1'($urandom_range(0, 99) < 70));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
